divider: RTL and testbench
==========================

Name: divider

Overview:
Multi-cycle signed 32-bit integer divider for the processor datapath. It is the inverse companion of the shift-and-add multiplier and writes the same HI/LO register pair: LO = quotient, HI = remainder, with MIPS DIV semantics. The control unit starts it with a one-cycle DivCtrl pulse, stalls, and waits for the DivOUT done pulse before reading HI/LO.

Parameters:
WIDTH, 32, operand, quotient and remainder width. Only 32 is required and verified.

Ports:
clk  input  1  clock; all state updates on the rising edge
DivReset  input  1  synchronous, active-high reset; clears all state and outputs
DivCtrl  input  1  start request, sampled only in IDLE
divA  input  WIDTH  dividend, two's complement, sampled at start
divB  input  WIDTH  divisor, two's complement, sampled at start
HI  output  WIDTH  remainder register
LO  output  WIDTH  quotient register
DivOUT  output  1  done pulse, high exactly one cycle per accepted start
DivZero  output  1  divide-by-zero flag, high only together with DivOUT

Behaviour:
- Reset (DivReset=1 at an edge): HI=0, LO=0, DivOUT=0, DivZero=0, state=IDLE, count=0, internal registers=0. DivReset has priority over everything and aborts an operation in progress with no done pulse.
- States: IDLE, RUN, FIX, DONE.
- IDLE: if DivCtrl=1 at edge E0:
  - Latch sign flags sA=divA[31], sB=divB[31], and magnitudes |divA| and |divB| (32-bit unsigned; |0x80000000|=0x80000000).
  - Clear the 33-bit partial remainder and count.
  - If divB==0, go to DONE. Otherwise go to RUN.
- RUN: one restoring step per cycle, 32 cycles (edges E1..E32):
  - rem = {rem[31:0], quo[31]}; quo <<= 1.
  - If rem >= |divB|: rem -= |divB| and quo[0] = 1.
  - count increments 0..31. On the step where count==31, go to FIX.
- FIX (edge E33):
  - LO = (sA^sB) ? -quo : quo.
  - HI = sA ? -rem[31:0] : rem[31:0].
  - DivOUT=1, then go to DONE.
- DONE (next edge): DivOUT=0, DivZero=0, go to IDLE.
- Divide by zero: at E1, DivOUT=1 and DivZero=1. HI and LO keep their previous values. At E2 both flags clear and the block returns to IDLE.
- Latency: DivOUT is visible after E33 for a nonzero divisor and after E1 for a zero divisor. It is high for exactly one cycle.
- HI/LO change only in FIX (or on reset) and hold their value otherwise.
- DivCtrl is ignored in RUN, FIX and DONE; there is no queuing. A new start is accepted in IDLE, at the earliest the cycle after DivOUT falls.
- Operand inputs may change freely after E0.
- Overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0. This falls out of the magnitude arithmetic and needs no special case.
- Truncation is toward zero. The remainder takes the dividend's sign.

Decomposition:
- Shared package: WIDTH constant; state enum (IDLE=2'd0, RUN=2'd1, FIX=2'd2, DONE=2'd3); ITER = WIDTH.
- Sub-module div_step: combinational single restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Instantiated once inside the RUN datapath.

Test Plan:
- divA=7, divB=2, pulse DivCtrl -> DivOUT after 33 cycles, LO=3, HI=1, DivZero=0.
- divA=-7 (0xFFFFFFF9), divB=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also check 7/-2 -> LO=-3, HI=1, and -7/-2 -> LO=3, HI=-1.
- divA=0x80000000, divB=0xFFFFFFFF -> LO=0x80000000, HI=0. Also divA=0x12345678, divB=1 -> LO=0x12345678, HI=0.
- Preload HI/LO with 7/2, then divA=5, divB=0 -> DivOUT=1 and DivZero=1 one cycle after start, HI=1 and LO=3 unchanged.
- Start 100/7, hold DivCtrl high, assert DivReset at cycle 15 -> HI=LO=0, no DivOUT. After release, 100/7 completes with LO=14, HI=2, exactly one done pulse.
- Back-to-back: start 9/4, re-pulse DivCtrl mid-RUN with 50/5 -> re-pulse ignored, result LO=2, HI=1. Then a new start on the cycle after DivOUT falls is accepted and yields LO=10, HI=0.

Source files
------------

// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared width, iteration count and FSM state encoding for the divider
package divider_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = WIDTH;
   localparam int CW    = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/divider_div_step.sv
// rtl/divider_div_step.sv - one combinational restoring-division step on unsigned magnitudes
module div_step
   import divider_pkg::*;
(
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] diff;

   // rem < divisor always holds, so the shifted value stays below 2*divisor and the
   // borrow out of the 33-bit subtraction is exactly the "rem_sh < divisor" test.
   always_comb begin
      rem_sh   = {rem, quo[WIDTH-1]};
      diff     = rem_sh - {1'b0, divisor};
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (!diff[WIDTH]) begin
         rem_next    = diff[WIDTH-1:0];
         quo_next[0] = 1'b1;
      end
   end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle signed divider writing LO=quotient, HI=remainder with a done pulse
module divider
   import divider_pkg::*;
(
   input  logic             clk,
   input  logic             DivReset,
   input  logic             DivCtrl,
   input  logic [WIDTH-1:0] divA,
   input  logic [WIDTH-1:0] divB,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             DivOUT,
   output logic             DivZero
);

   state_t           state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             sa_q, sa_d;
   logic             sb_q, sb_d;
   logic             done_q, done_d;
   logic             zero_q, zero_d;
   logic             zpend_q, zpend_d;
   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   div_step u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      done_d  = done_q;
      zero_d  = zero_q;
      zpend_d = zpend_q;
      case (state_q)
         IDLE: begin
            if (DivCtrl) begin
               sa_d    = divA[WIDTH-1];
               sb_d    = divB[WIDTH-1];
               quo_d   = divA[WIDTH-1] ? -divA : divA;
               dvs_d   = divB[WIDTH-1] ? -divB : divB;
               rem_d   = '0;
               count_d = '0;
               if (divB == '0) begin
                  zpend_d = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            count_d = count_q + CW'(1);
            if (count_q == CW'(ITER - 1)) state_d = FIX;
         end
         FIX: begin
            lo_d    = (sa_q ^ sb_q) ? -quo_q : quo_q;
            hi_d    = sa_q ? -rem_q : rem_q;
            done_d  = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            // A zero divisor lingers one extra cycle here to raise its flags.
            if (zpend_q) begin
               done_d  = 1'b1;
               zero_d  = 1'b1;
               zpend_d = 1'b0;
            end else begin
               done_d  = 1'b0;
               zero_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (DivReset) begin
         state_q <= IDLE;
         count_q <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
         zpend_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
         zpend_q <= zpend_d;
      end
   end

   assign HI      = hi_q;
   assign LO      = lo_q;
   assign DivOUT  = done_q;
   assign DivZero = zero_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - directed self-checking bench for the signed divider
module tb_divider;

   logic        clk = 1'b0;
   logic        DivReset;
   logic        DivCtrl;
   logic [31:0] divA;
   logic [31:0] divB;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        DivOUT;
   logic        DivZero;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   divider dut (
      .clk      (clk),
      .DivReset (DivReset),
      .DivCtrl  (DivCtrl),
      .divA     (divA),
      .divB     (divB),
      .HI       (HI),
      .LO       (LO),
      .DivOUT   (DivOUT),
      .DivZero  (DivZero)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input int start_cnt, output int lat);
      lat = start_cnt;
      while (DivOUT !== 1'b1 && lat < start_cnt + 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_zero, input int exp_lat);
      int lat;
      divA    = a;
      divB    = b;
      DivCtrl = 1'b1;
      @(posedge clk);
      #1;
      DivCtrl = 1'b0;
      divA    = $urandom;
      divB    = $urandom;
      wait_done(0, lat);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_out"}, DivOUT, 1'b1);
      check({tag, "_lo"}, LO, exp_lo);
      check({tag, "_hi"}, HI, exp_hi);
      check({tag, "_zero"}, DivZero, exp_zero);
      @(posedge clk);
      #1;
      check({tag, "_out_fall"}, DivOUT, 1'b0);
      check({tag, "_zero_fall"}, DivZero, 1'b0);
   endtask

   initial begin
      int pulses;
      int lat;
      logic [31:0] cap_lo;
      logic [31:0] cap_hi;

      DivReset = 1'b1;
      DivCtrl  = 1'b0;
      divA     = 32'hDEADBEEF;
      divB     = 32'h12345678;
      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", HI, 32'h0);
      check("rst_lo", LO, 32'h0);
      check("rst_out", DivOUT, 1'b0);
      check("rst_zero", DivZero, 1'b0);
      DivReset = 1'b0;
      @(posedge clk);
      #1;

      run_div("p7_p2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
      run_div("n7_p2", 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
      run_div("p7_n2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 33);
      run_div("n7_n2", 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 1'b0, 33);
      run_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 33);
      run_div("div1", 32'h12345678, 32'd1, 32'h12345678, 32'h0, 1'b0, 33);
      run_div("pre7_2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);
      run_div("zero", 32'd5, 32'd0, 32'd3, 32'd1, 1'b1, 1);

      divA    = 32'd100;
      divB    = 32'd7;
      DivCtrl = 1'b1;
      @(posedge clk);
      #1;
      pulses = 0;
      repeat (14) begin
         @(posedge clk);
         #1;
         if (DivOUT) pulses++;
      end
      DivReset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_hi", HI, 32'h0);
      check("abort_lo", LO, 32'h0);
      check("abort_out", DivOUT, 1'b0);
      check("abort_no_pulse", pulses, 32'd0);
      DivReset = 1'b0;
      @(posedge clk);
      #1;
      DivCtrl = 1'b0;
      pulses  = 0;
      lat     = 0;
      cap_lo  = 32'hX;
      cap_hi  = 32'hX;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk);
         #1;
         if (DivOUT) begin
            pulses++;
            lat    = i;
            cap_lo = LO;
            cap_hi = HI;
         end
      end
      check("restart_pulses", pulses, 32'd1);
      check("restart_lat", lat, 32'd33);
      check("restart_lo", cap_lo, 32'd14);
      check("restart_hi", cap_hi, 32'd2);

      divA    = 32'd9;
      divB    = 32'd4;
      DivCtrl = 1'b1;
      @(posedge clk);
      #1;
      DivCtrl = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      divA    = 32'd50;
      divB    = 32'd5;
      DivCtrl = 1'b1;
      @(posedge clk);
      #1;
      DivCtrl = 1'b0;
      wait_done(11, lat);
      check("b2b_lat", lat, 32'd33);
      check("b2b_lo", LO, 32'd2);
      check("b2b_hi", HI, 32'd1);
      @(posedge clk);
      #1;
      check("b2b_out_fall", DivOUT, 1'b0);
      run_div("b2b_next", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
